state_dump_ctrl: RTL
====================

# state_dump_ctrl

Parametrised end-of-run state dump controller for the RISC-V processor. It freezes the core, then walks the register file and the low region of data memory and streams every word out on a valid/ready channel tagged with space and index. It replaces fixed-time, hierarchical-peek dumps with a synthesizable, back-pressured dump triggered by a cycle budget or an explicit request. It sits beside `processador`, owns the halt input and one read port on each of `breg` and `dmem`.

## Interface
- `XLEN`, 32: word width; `XLEN/8` bytes per word.
- `NREGS`, 32: register-file entries dumped, indices 0..NREGS-1.
- `MEM_BYTES`, 32: bytes of data memory dumped from address 0; multiple of `XLEN/8`.
- `TIMEOUT`, 200: cycles after reset release before an automatic dump; 0 disables the automatic dump.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: dump request, sampled in RUN.
- `cpu_halt` out 1: stalls the core while high.
- `rf_raddr` out $clog2(NREGS): register-file read address.
- `rf_rdata` in XLEN: combinational read data.
- `dm_raddr` out $clog2(MEM_BYTES): data-memory byte address.
- `dm_rdata` in XLEN: little-endian word at `dm_raddr`, registered, 1-cycle latency.
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_space` out 1: 0 = register, 1 = memory.
- `out_index` out max($clog2(NREGS),$clog2(MEM_BYTES)): register number or byte address.
- `out_data` out XLEN: dumped word.
- `busy` out 1: dump in progress.
- `done` out 1: dump complete.

## Operation
- States: RUN, HALT, RF, MEM_ISSUE, MEM_LOAD, FLUSH, DONE.
- RUN: 32-bit `cyc` increments every cycle.
  - Go to HALT when `start`=1.
  - Also go to HALT when `TIMEOUT`≠0 and `cyc`==TIMEOUT-1.
- HALT:
  - `cpu_halt`=1 from this state onward.
  - Hold one cycle so the in-flight writeback retires.
  - Then go to RF with `idx`=0.
- RF:
  - `rf_raddr`=`idx`.
  - When the slot is free (`!out_valid || out_ready`), load `out_data`←`rf_rdata`, `out_space`=0, `out_index`=`idx`, `out_valid`=1, then `idx`++.
  - After loading NREGS-1, go to MEM_ISSUE with `addr`=0.
- MEM_ISSUE: drive `dm_raddr`=`addr`, go to MEM_LOAD.
- MEM_LOAD:
  - Hold `dm_raddr`=`addr` stable, so `dm_rdata` stays stable under back-pressure.
  - When the slot is free, load `dm_rdata`, `out_space`=1, `out_index`=`addr`, then `addr`+=XLEN/8.
  - After MEM_BYTES-XLEN/8, go to FLUSH; otherwise go to MEM_ISSUE.
- FLUSH: wait for the last beat to be accepted, then go to DONE.
- DONE:
  - `done`=1, `busy`=0, `cpu_halt` stays 1.
  - `start` is ignored; only `rst` leaves DONE.
- `busy`=1 in HALT, RF, MEM_ISSUE, MEM_LOAD and FLUSH.
- Stream rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_space` and `out_index` hold stable.
  - `out_valid` never drops without a handshake.
- Beat count per dump: NREGS + MEM_BYTES/(XLEN/8), in order: all registers ascending, then memory ascending.
- Arithmetic:
  - `idx` and `addr` never wrap inside a dump; termination compares the last value, not overflow.
  - `cyc` saturates at all-ones.

## Timing
- Reset values: `cpu_halt`=0, `busy`=0, `done`=0, `out_valid`=0, `out_space`=0, `out_index`=0, `out_data`=0, `rf_raddr`=0, `dm_raddr`=0; state RUN, `cyc`=0.
- Reset asserted mid-dump: everything returns to reset values asynchronously. The partial beat is discarded and `cpu_halt` drops.
- Latency:
  - `start` high at edge N → `cpu_halt`=1 after edge N.
  - First `out_valid` after edge N+2.
- With `out_ready` held at 1:
  - Register beats come one per cycle.
  - Memory beats come one per 2 cycles.
  - The full 32+8 default dump is accepted within 2+32+16+1 cycles of the trigger.
- Timeout with TIMEOUT=T: `cpu_halt` rises after the T-th rising edge following reset release.
- `start` and timeout in the same cycle: a single dump.
- `out_ready` low throughout: the first beat is held, with no index advance and no read-address change.

## Test plan
- Reset release, TIMEOUT=0, no `start` for 500 cycles → `cpu_halt`=0, `out_valid`=0, `busy`=0 throughout.
- Preload x5=0x0000_00AA, dmem[4..7]=44 33 22 11; pulse `start`, `out_ready`=1 → 40 beats; beat 5 is {0,5,0x000000AA}, beat 33 is {1,4,0x11223344}; `done`=1 one cycle after the last beat.
- TIMEOUT=200, no `start` → `cpu_halt` rises exactly 200 cycles after reset release; beat 0 is {0,0,0x00000000}.
- Random `out_ready` (~30% duty) → 40 beats, indices strictly ascending, fields constant while stalled, none lost or duplicated.
- `rst` asserted during beat 20 → all outputs reach reset values immediately; a second `start` gives a full 40-beat dump starting at index 0.
- NREGS=16, MEM_BYTES=64, XLEN=32 → 16 register beats, then 16 memory beats at addresses 0,4..60, then `done`.

Source files
------------

// File: rtl/state_dump_ctrl.sv
// ---------------------------------------------------------------------------
// state_dump_ctrl
//
// End-of-run state dump controller. Once triggered (explicit start request or
// a cycle budget after reset release) it halts the core, waits one cycle for
// the in-flight writeback to retire, then streams every register-file word
// followed by every word of the low data-memory region out on a valid/ready
// channel. Each beat is tagged with its space (0 = register, 1 = memory) and
// its index (register number or byte address). After the last beat is
// accepted the block parks in DONE with the core still halted until reset.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   start      in   dump request, honoured only while the core is running
//   cpu_halt   out  stalls the core while high
//   rf_raddr   out  register-file read address
//   rf_rdata   in   register-file read data, combinational
//   dm_raddr   out  data-memory byte address
//   dm_rdata   in   little-endian word at dm_raddr, one-cycle read latency
//   out_valid  out  beat available
//   out_ready  in   sink accepts the beat
//   out_space  out  0 = register beat, 1 = memory beat
//   out_index  out  register number or memory byte address of the beat
//   out_data   out  dumped word
//   busy       out  dump in progress
//   done       out  dump complete
// ---------------------------------------------------------------------------
module state_dump_ctrl #(
  parameter int  XLEN      = 32,
  parameter int  NREGS     = 32,
  parameter int  MEM_BYTES = 32,
  parameter int  TIMEOUT   = 200,
  localparam int RF_AW     = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int MA_W      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1,
  localparam int IDX_W     = (RF_AW > MA_W) ? RF_AW : MA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             cpu_halt,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic [MA_W-1:0]  dm_raddr,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_space,
  output logic [IDX_W-1:0] out_index,
  output logic [XLEN-1:0]  out_data,
  output logic             busy,
  output logic             done
);

  localparam int               BPW       = XLEN / 8;
  localparam logic [RF_AW-1:0] LAST_IDX  = RF_AW'(NREGS - 1);
  localparam logic [MA_W-1:0]  LAST_ADDR = MA_W'(MEM_BYTES - BPW);
  localparam logic [MA_W-1:0]  ADDR_STEP = MA_W'(BPW);
  localparam logic [31:0]      CYC_TRIG  = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT,
    S_RF,
    S_MEM_ISSUE,
    S_MEM_LOAD,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        cyc_q, cyc_d;
  logic [RF_AW-1:0]   idx_q, idx_d;
  logic [MA_W-1:0]    addr_q, addr_d;
  logic               out_valid_q, out_valid_d;
  logic               out_space_q, out_space_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic [XLEN-1:0]    out_data_q, out_data_d;

  logic               slot_free;
  logic               timeout_hit;

  // The output register can take a new beat when it is empty or its current
  // beat is being accepted this cycle.
  assign slot_free   = !out_valid_q || out_ready;
  assign timeout_hit = (TIMEOUT != 0) && (cyc_q == CYC_TRIG);

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q && !out_ready;
    out_space_d = out_space_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      S_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        if (start || timeout_hit) state_d = S_HALT;
      end

      // One idle cycle with the core halted lets the writeback retire.
      S_HALT: begin
        idx_d   = '0;
        state_d = S_RF;
      end

      S_RF: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_space_d = 1'b0;
          out_index_d = IDX_W'(idx_q);
          out_data_d  = rf_rdata;
          // Terminate on the last index rather than relying on overflow.
          if (idx_q == LAST_IDX) begin
            addr_d  = '0;
            state_d = S_MEM_ISSUE;
          end else begin
            idx_d = idx_q + RF_AW'(1);
          end
        end
      end

      // Address is already on dm_raddr; the word appears next cycle.
      S_MEM_ISSUE: state_d = S_MEM_LOAD;

      // addr_q does not move while stalled, so dm_rdata stays valid.
      S_MEM_LOAD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_space_d = 1'b1;
          out_index_d = IDX_W'(addr_q);
          out_data_d  = dm_rdata;
          if (addr_q == LAST_ADDR) begin
            state_d = S_FLUSH;
          end else begin
            addr_d  = addr_q + ADDR_STEP;
            state_d = S_MEM_ISSUE;
          end
        end
      end

      S_FLUSH: begin
        if (slot_free) state_d = S_DONE;
      end

      // Sticky until reset; start is deliberately ignored here.
      S_DONE: ;

      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      cyc_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_space_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_space_q <= out_space_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cpu_halt  = (state_q != S_RUN);
  assign busy      = (state_q != S_RUN) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign rf_raddr  = idx_q;
  assign dm_raddr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_space = out_space_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;

endmodule
